// File: rtl/slot_pkg.sv
// Shared definitions for the slot game controller: FSM encoding, payout
// multipliers, bet range and datapath widths.
package slot_pkg;

  localparam int CREDIT_W = 10;
  localparam int REEL_W   = 10;
  localparam int BET_W    = 2;

  localparam logic [BET_W-1:0] BET_MIN = 2'd1;
  localparam logic [BET_W-1:0] BET_MAX = 2'd3;

  localparam int unsigned PAY_TRIPLE = 10;
  localparam int unsigned PAY_DOUBLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_EVAL = 2'd2,
    ST_PAY  = 2'd3
  } state_t;

  function automatic logic [BET_W-1:0] next_bet(input logic [BET_W-1:0] b);
    return (b >= BET_MAX) ? BET_MIN : b + 2'd1;
  endfunction

endpackage

// File: rtl/payout_calc.sv
// Combinational payout decode: splits the reel value into decimal digits and
// classifies triple / pair / nothing, scaled by the round's bet.
module payout_calc
  import slot_pkg::*;
(
  input  logic [REEL_W-1:0]   reel_val,
  input  logic [BET_W-1:0]    bet,
  output logic [CREDIT_W-1:0] payout
);

  logic [3:0]        d2, d1, d0;
  logic [REEL_W-1:0] tens;
  logic              triple, pair;

  always_comb begin
    d0     = 4'(reel_val % 10);
    tens   = REEL_W'(reel_val / 10);
    d1     = 4'(tens % 10);
    d2     = 4'(tens / 10);
    triple = (d2 == d1) && (d1 == d0);
    pair   = !triple && ((d2 == d1) || (d1 == d0) || (d2 == d0));
    payout = '0;
    // Values above 999 are not valid three-digit results and never pay.
    if (reel_val <= 10'd999) begin
      if (triple)    payout = CREDIT_W'(PAY_TRIPLE * bet);
      else if (pair) payout = CREDIT_W'(PAY_DOUBLE * bet);
    end
  end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot game round controller: credit/bet bookkeeping, spin handshake with the
// reel datapath, spin timeout with refund, and saturating payout credit.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned MAX_CREDIT   = 999,
  parameter int unsigned SPIN_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic                bet_inc,
  input  logic                start,
  input  logic                reel_done,
  input  logic [REEL_W-1:0]   reel_val,
  output logic                spin_go,
  output logic                busy,
  output logic [CREDIT_W-1:0] credits,
  output logic [BET_W-1:0]    bet,
  output logic [CREDIT_W-1:0] payout,
  output logic                won,
  output logic                err_timeout
);

  localparam int TO_W  = $clog2(SPIN_TIMEOUT + 1);
  localparam int SUM_W = CREDIT_W + 2;

  state_t              state, state_next;
  logic [TO_W-1:0]     to_cnt;
  logic [REEL_W-1:0]   reel_q;
  logic [BET_W-1:0]    round_bet;
  logic [CREDIT_W-1:0] calc_payout;
  logic                spin_go_q;
  logic                accept, timeout, capture, paying;
  logic [SUM_W-1:0]    credit_sum;
  logic [CREDIT_W-1:0] credit_next;

  payout_calc u_payout (
    .reel_val (reel_q),
    .bet      (round_bet),
    .payout   (calc_payout)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_SPIN;
      ST_SPIN: begin
        if (capture)      state_next = ST_EVAL;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_EVAL: state_next = ST_PAY;
      ST_PAY:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    accept  = (state == ST_IDLE) && start && (credits >= CREDIT_W'(bet));
    capture = (state == ST_SPIN) && reel_done;
    timeout = (state == ST_SPIN) && !reel_done && (to_cnt == TO_W'(SPIN_TIMEOUT - 1));
    paying  = (state == ST_PAY);
    // Gated so a pulse already in flight is suppressed while reset is held.
    spin_go = spin_go_q & rst;
  end

  // Coin, deduction, refund and payout all fold into one saturating update.
  always_comb begin
    credit_sum = SUM_W'(credits) + SUM_W'(coin);
    if (timeout) credit_sum = credit_sum + SUM_W'(round_bet);
    if (paying)  credit_sum = credit_sum + SUM_W'(payout);
    if (accept)  credit_sum = credit_sum - SUM_W'(bet);
    credit_next = (credit_sum > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT)
                                                    : credit_sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credits     <= '0;
      bet         <= BET_MIN;
      round_bet   <= BET_MIN;
      payout      <= '0;
      won         <= 1'b0;
      err_timeout <= 1'b0;
      spin_go_q   <= 1'b0;
      to_cnt      <= '0;
      reel_q      <= '0;
    end else begin
      credits   <= credit_next;
      spin_go_q <= accept;
      to_cnt    <= (state == ST_SPIN && state_next == ST_SPIN) ? to_cnt + 1'b1 : '0;
      if (state == ST_IDLE && bet_inc) bet <= next_bet(bet);
      if (accept) begin
        round_bet   <= bet;
        payout      <= '0;
        won         <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (capture)           reel_q      <= reel_val;
      if (timeout)           err_timeout <= 1'b1;
      if (state == ST_EVAL)  payout      <= calc_payout;
      if (paying)            won         <= (payout != '0);
    end
  end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Self-checking bench for slot_game_ctrl: per-scenario tasks with a scoreboard
// of expected end-of-round results.
module tb_slot_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin = 1'b0, bet_inc = 1'b0, start = 1'b0, reel_done = 1'b0;
  logic [9:0] reel_val = '0;
  logic       spin_go, busy, won, err_timeout;
  logic [9:0] credits, payout;
  logic [1:0] bet;

  typedef struct packed {
    logic [9:0] credits;
    logic [9:0] payout;
    logic       won;
    logic       err;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  slot_game_ctrl #(.MAX_CREDIT(999), .SPIN_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .coin(coin), .bet_inc(bet_inc), .start(start),
    .reel_done(reel_done), .reel_val(reel_val), .spin_go(spin_go), .busy(busy),
    .credits(credits), .bet(bet), .payout(payout), .won(won), .err_timeout(err_timeout)
  );

  function automatic string fmt(input res_t r);
    return $sformatf("credits=%0d payout=%0d won=%0b err=%0b", r.credits, r.payout, r.won, r.err);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic coins(input int n);
    coin = 1'b1; tick(n); coin = 1'b0;
  endtask

  task automatic bump_bet(input int n);
    repeat (n) begin bet_inc = 1'b1; tick(); bet_inc = 1'b0; end
  endtask

  task automatic do_reset;
    rst = 1'b0; tick(2); rst = 1'b1;
  endtask

  task automatic press_start;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic spin_result(input logic [9:0] v);
    reel_val = v; reel_done = 1'b1; tick(); reel_done = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; tick(2);
    checks++;
    if (credits !== 10'd0 || bet !== 2'd1 || payout !== 10'd0) begin
      errors++; $display("FAIL reset_regs credits=%0d bet=%0d payout=%0d required 0 1 0", credits, bet, payout);
    end
    checks++;
    if ({won, err_timeout, busy, spin_go} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags won/err/busy/spin_go=%b required 0000", {won, err_timeout, busy, spin_go});
    end
    rst = 1'b1;
  endtask

  task automatic test_win_triple;
    res_t got, exp; bit ok;
    coins(5);
    checks++; if (credits !== 10'd5) begin errors++; $display("FAIL coins5 credits=%0d required 5", credits); end
    sb.push_back('{credits: 10'd14, payout: 10'd10, won: 1'b1, err: 1'b0});
    press_start;
    checks++;
    if (spin_go !== 1'b1 || busy !== 1'b1 || credits !== 10'd4) begin
      errors++; $display("FAIL 777_start spin_go=%b busy=%b credits=%0d required 1 1 4", spin_go, busy, credits);
    end
    tick();
    checks++; if (spin_go !== 1'b0) begin errors++; $display("FAIL 777_pulse spin_go=%b required 0", spin_go); end
    tick(2);
    spin_result(10'd777);
    tick();
    checks++;
    if (credits !== 10'd4 || payout !== 10'd10) begin
      errors++; $display("FAIL 777_eval credits=%0d payout=%0d required 4 10", credits, payout);
    end
    tick();
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL 777_idle busy=%b required 0", busy); end
    exp = sb.pop_front(); got = {credits, payout, won, err_timeout};
    checks++; if (got !== exp) begin errors++; $display("FAIL 777_round got %s required %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_win_pair;
    res_t got, exp; bit ok;
    do_reset;
    coins(3); bump_bet(2);
    checks++; if (bet !== 2'd3) begin errors++; $display("FAIL bet3 bet=%0d required 3", bet); end
    sb.push_back('{credits: 10'd6, payout: 10'd6, won: 1'b1, err: 1'b0});
    press_start;
    checks++; if (credits !== 10'd0) begin errors++; $display("FAIL 455_deduct credits=%0d required 0", credits); end
    tick(2);
    spin_result(10'd455);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL 455_idle busy=%b required 0", busy); end
    exp = sb.pop_front(); got = {credits, payout, won, err_timeout};
    checks++; if (got !== exp) begin errors++; $display("FAIL 455_round got %s required %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_insufficient;
    do_reset;
    coins(2); bump_bet(2);
    press_start;
    checks++;
    if (spin_go !== 1'b0 || busy !== 1'b0 || credits !== 10'd2) begin
      errors++; $display("FAIL low_credit spin_go=%b busy=%b credits=%0d required 0 0 2", spin_go, busy, credits);
    end
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL low_credit_hold busy=%b required 0", busy); end
    bump_bet(1);
    checks++; if (bet !== 2'd1) begin errors++; $display("FAIL bet_wrap bet=%0d required 1", bet); end
  endtask

  task automatic test_timeout;
    res_t got, exp; bit ok;
    do_reset;
    coins(1);
    sb.push_back('{credits: 10'd1, payout: 10'd0, won: 1'b0, err: 1'b1});
    press_start;
    checks++; if (credits !== 10'd0) begin errors++; $display("FAIL to_deduct credits=%0d required 0", credits); end
    tick(254);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_early busy=%b required 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_expire busy=%b required 0", busy); end
    wait_idle(ok);
    exp = sb.pop_front(); got = {credits, payout, won, err_timeout};
    checks++; if (got !== exp) begin errors++; $display("FAIL to_round got %s required %s", fmt(got), fmt(exp)); end
    spin_result(10'd333);
    tick(2);
    checks++;
    if (credits !== 10'd1 || busy !== 1'b0 || won !== 1'b0 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL stray_reel credits=%0d busy=%b won=%b err=%b required 1 0 0 1", credits, busy, won, err_timeout);
    end
  endtask

  task automatic test_saturate;
    res_t got, exp; bit ok;
    do_reset;
    coins(995);
    checks++; if (credits !== 10'd995) begin errors++; $display("FAIL coins995 credits=%0d required 995", credits); end
    sb.push_back('{credits: 10'd999, payout: 10'd10, won: 1'b1, err: 1'b0});
    press_start;
    tick();
    spin_result(10'd0);
    tick();
    coin = 1'b1; tick(); coin = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_idle busy=%b required 0", busy); end
    exp = sb.pop_front(); got = {credits, payout, won, err_timeout};
    checks++; if (got !== exp) begin errors++; $display("FAIL sat_round got %s required %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_back_to_back;
    res_t got, exp; bit ok;
    do_reset;
    coins(4);
    sb.push_back('{credits: 10'd7, payout: 10'd2, won: 1'b1, err: 1'b0});
    coin = 1'b1; start = 1'b1; bet_inc = 1'b1; tick();
    coin = 1'b0; start = 1'b0; bet_inc = 1'b0;
    checks++;
    if (credits !== 10'd4 || bet !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL coincident credits=%0d bet=%0d busy=%b required 4 2 1", credits, bet, busy);
    end
    bump_bet(1);
    coins(1);
    checks++;
    if (bet !== 2'd2 || credits !== 10'd5) begin
      errors++; $display("FAIL busy_inputs bet=%0d credits=%0d required 2 5", bet, credits);
    end
    spin_result(10'd112);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b1_idle busy=%b required 0", busy); end
    exp = sb.pop_front(); got = {credits, payout, won, err_timeout};
    checks++; if (got !== exp) begin errors++; $display("FAIL old_bet_round got %s required %s", fmt(got), fmt(exp)); end
    sb.push_back('{credits: 10'd25, payout: 10'd20, won: 1'b1, err: 1'b0});
    press_start;
    checks++;
    if (credits !== 10'd5 || payout !== 10'd0 || won !== 1'b0) begin
      errors++; $display("FAIL b2b_clear credits=%0d payout=%0d won=%b required 5 0 0", credits, payout, won);
    end
    spin_result(10'd999);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b2_idle busy=%b required 0", busy); end
    exp = sb.pop_front(); got = {credits, payout, won, err_timeout};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_round got %s required %s", fmt(got), fmt(exp)); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    coins(3);
    press_start;
    checks++; if (spin_go !== 1'b1) begin errors++; $display("FAIL mid_spin_go spin_go=%b required 1", spin_go); end
    rst = 1'b0; #1;
    checks++; if (spin_go !== 1'b0) begin errors++; $display("FAIL rst_gate spin_go=%b required 0", spin_go); end
    tick();
    rst = 1'b1;
    checks++;
    if (credits !== 10'd0 || bet !== 2'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset credits=%0d bet=%0d busy=%b required 0 1 0", credits, bet, busy);
    end
    spin_result(10'd777);
    tick(3);
    checks++;
    if (credits !== 10'd0 || busy !== 1'b0 || payout !== 10'd0) begin
      errors++; $display("FAIL post_reset_reel credits=%0d busy=%b payout=%0d required 0 0 0", credits, busy, payout);
    end
  endtask

  initial begin
    test_reset;
    test_win_triple;
    test_win_pair;
    test_insufficient;
    test_timeout;
    test_saturate;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left size=%0d required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/slot_game_ctrl.md
SLOT_GAME_CTRL -- requirements
Module: slot_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_CREDIT, default 999: saturation ceiling of the credit register.
REQ-002 SHALL have parameter SPIN_TIMEOUT, default 255: clk cycles allowed between spin_go and reel_done.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port coin, input, 1: single-cycle pulse, one credit inserted.
REQ-006 SHALL have port bet_inc, input, 1: single-cycle pulse, advance bet 1->2->3->1.
REQ-007 SHALL have port start, input, 1: single-cycle pulse, request a round.
REQ-008 SHALL have port reel_done, input, 1: single-cycle pulse from the reel datapath, reel_val valid.
REQ-009 SHALL have port reel_val, input, 10: reel result, binary 0..999.
REQ-010 SHALL have port spin_go, output, 1: single-cycle pulse to the reel datapath, spin begins.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port credits, output, 10: current credit balance.
REQ-013 SHALL have port bet, output, 2: current bet, range 1..3.
REQ-014 SHALL have port payout, output, 10: payout of the last completed round.
REQ-015 SHALL have port won, output, 1: last round paid more than zero.
REQ-016 SHALL have port err_timeout, output, 1: last round aborted by timeout.

Function
REQ-017 SHALL implement the states IDLE, SPIN, EVAL and PAY, with encodings from the shared package.
REQ-018 SHALL, in IDLE, on start with credits >= bet:
- deduct bet from credits;
- pulse spin_go on the next cycle;
- clear won, payout and err_timeout;
- enter SPIN.
REQ-019 SHALL ignore start, with no state change, when credits < bet or busy is high.
REQ-020 SHALL, in SPIN, on reel_done capture reel_val and enter EVAL.
REQ-021 SHALL, if SPIN_TIMEOUT cycles elapse in SPIN without reel_done:
- refund bet to credits;
- set err_timeout;
- return to IDLE.
REQ-022 SHALL compute payout in EVAL (one cycle) from the decimal digits of the captured value:
- all three digits equal (value % 111 == 0): 10*bet;
- exactly two digits equal: 2*bet;
- otherwise: 0;
- value > 999: 0.
REQ-023 SHALL, in PAY (one cycle):
- add payout to credits, saturating at MAX_CREDIT;
- set won = (payout != 0);
- return to IDLE.
REQ-024 SHALL latency be start -> spin_go 1 cycle, and reel_done -> credits updated 2 cycles (EVAL, PAY).
REQ-025 SHALL accept coin in every state, incrementing credits saturating at MAX_CREDIT.
REQ-026 SHALL, on coin coinciding with a deduction, refund or payout, apply both changes in the same cycle, saturating the net result.
REQ-027 SHALL act on bet_inc only in IDLE and ignore it otherwise.
REQ-028 SHALL ignore reel_done outside SPIN.
REQ-029 SHALL treat a start coincident with bet_inc as using the old bet.
REQ-030 SHALL hold payout, won and err_timeout stable until the next accepted start.

Reset
REQ-031 SHALL, on rst low at a rising clk edge:
- state = IDLE;
- credits = 0, bet = 1, payout = 0;
- won, err_timeout, busy and spin_go = 0;
- timeout counter = 0.
REQ-032 SHALL treat rst mid-round as aborting the round with no refund.
REQ-033 SHALL NOT issue spin_go in the cycle that rst is low.

Structure
REQ-034 SHALL place the state encodings, payout multipliers (10, 2) and bet range limits in the shared package slot_pkg.
REQ-035 SHALL put digit extraction and payout-class decoding in one combinational sub-module, payout_calc (inputs reel_val and bet; output payout).
REQ-036 SHALL keep the timeout counter 8 bits wide for the default SPIN_TIMEOUT, sized from the parameter.

Verification
REQ-037 SHALL cover: 5 coins, bet 1, start, reel_done with 777 -> credits 4 then 14, won=1, payout=10.
REQ-038 SHALL cover: credits 3, bet 3, start, reel_done with 455 -> credits 0 then 6, won=1.
REQ-039 SHALL cover: credits 2, bet 3, start -> no spin_go, busy stays 0, credits stay 2.
REQ-040 SHALL cover: credits 1, start, no reel_done for 255 cycles -> credits back to 1, err_timeout=1, state IDLE.
REQ-041 SHALL cover: credits 995, bet 1, reel_done with 000, coin in the PAY cycle -> credits saturate at 999.
REQ-042 SHALL cover: rst low during SPIN -> next cycle credits 0, bet 1, busy 0; a later reel_done is ignored.
